sram_access_arbiter: RTL and testbench

//  Sequences and shares one sram_4kb_256x128x8 macro between two requesters
//  (port 0: image loader; port 1: convolution engine).

---
 rtl/sram_access_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_access_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Two-port round-robin arbiter and timing sequencer for a single 4096x8 SRAM macro.
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
module sram_access_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int WR_CYCLES    = 2,
    parameter int SENSE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy,
    output logic                  sram_write_en,
    output logic                  sram_sense_en,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_din,
    input  logic [DATA_W-1:0]     sram_dout
);

    localparam int CNT_MAX = (WR_CYCLES > SENSE_CYCLES) ? WR_CYCLES : SENSE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SENSE = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                owner_r;
    logic                rr_ptr_r;
    logic                grant_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                sel_we_s;

    // Grant selection; with fixed priority rr_ptr_r is held at 0 so port 0 wins ties.
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = rr_ptr_r;
            default: grant_s = 1'b0;
        endcase
    end

    // Ready is offered only in IDLE and is forced low while reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        if (!reset && (state_r == IDLE) && (req_valid != 2'b00)) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Command fields of the granted port.
    always_comb begin
        if (grant_s) begin
            sel_addr_s  = req_addr[2*ADDR_W-1:ADDR_W];
            sel_wdata_s = req_wdata[2*DATA_W-1:DATA_W];
            sel_we_s    = req_we[1];
        end else begin
            sel_addr_s  = req_addr[ADDR_W-1:0];
            sel_wdata_s = req_wdata[DATA_W-1:0];
            sel_we_s    = req_we[0];
        end
        accept_s = |(req_valid & req_ready);
    end

    // Sequencer FSM with all macro-facing and response outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            owner_r       <= 1'b0;
            rr_ptr_r      <= 1'b0;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= {DATA_W{1'b0}};
            busy          <= 1'b0;
            sram_write_en <= 1'b0;
            sram_sense_en <= 1'b1;
            sram_addr     <= {ADDR_W{1'b0}};
            sram_din      <= {DATA_W{1'b0}};
        end else begin
            rsp_valid <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r   <= grant_s;
                        sram_addr <= sel_addr_s;
                        sram_din  <= sel_wdata_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        busy      <= 1'b1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
                        rr_ptr_r  <= 1'b0;
`else
                        rr_ptr_r  <= ~grant_s;
`endif
                        if (sel_we_s) begin
                            state_r       <= WRITE;
                            sram_write_en <= 1'b1;
                        end else begin
                            state_r       <= SENSE;
                            sram_sense_en <= 1'b0;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                WRITE: begin
                    if (cnt_r == CNT_W'(WR_CYCLES - 1)) begin
                        state_r       <= IDLE;
                        sram_write_en <= 1'b0;
                        busy          <= 1'b0;
                        cnt_r         <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                SENSE: begin
                    if (cnt_r == CNT_W'(SENSE_CYCLES - 1)) begin
                        state_r       <= LATCH;
                        sram_sense_en <= 1'b1;
                        cnt_r         <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                LATCH: begin
                    rsp_rdata          <= sram_dout;
                    rsp_valid[owner_r] <= 1'b1;
                    state_r            <= IDLE;
                    busy               <= 1'b0;
                    cnt_r              <= {CNT_W{1'b0}};
                end
                default: begin
                    state_r       <= IDLE;
                    busy          <= 1'b0;
                    sram_write_en <= 1'b0;
                    sram_sense_en <= 1'b1;
                    cnt_r         <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter with a behavioural SRAM and a response scoreboard.
module tb_sram_access_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic            sram_write_en;
    logic            sram_sense_en;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_din;
    logic [DW-1:0]   sram_dout;

    sram_access_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural macro: writes while write_en is high, senses while sense_en is low.
    logic [7:0] sram_mem [0:4095];
    always @(posedge clk) begin
        if (sram_write_en) sram_mem[sram_addr] <= sram_din;
        if (!sram_sense_en) sram_dout <= sram_mem[sram_addr];
    end

    typedef struct {
        int         port;
        logic [7:0] data;
        bit         chk_data;
    } rsp_t;

    typedef struct {
        int          port;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    rsp_t       sb[$];
    vec_t       vecs[8];
    logic [7:0] ref_mem [0:4095];
    int         checks   = 0;
    int         failures = 0;
    int         overlap  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_write_en"}, 32'(sram_write_en), 32'h0);
        chk({tag, "_sense_en"}, 32'(sram_sense_en), 32'h1);
        chk({tag, "_addr"}, 32'(sram_addr), 32'h0);
        chk({tag, "_din"}, 32'(sram_din), 32'h0);
    endtask

    // Response monitor and write/sense overlap counter.
    initial begin
        rsp_t       e;
        logic [1:0] exp_v;
        forever begin
            @(negedge clk);
            if (sram_write_en && !sram_sense_en) overlap++;
            if (!reset && rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b required none", rsp_valid);
                end else begin
                    e = sb.pop_front();
                    exp_v = (e.port == 1) ? 2'b10 : 2'b01;
                    chk("rsp_port", 32'(rsp_valid), 32'(exp_v));
                    if (e.chk_data) chk("rsp_data", 32'(rsp_rdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    // Drives one command on port p; returns just after the accepting edge (start of cycle N+1).
    task automatic issue(input int p, input logic we, input logic [11:0] a, input logic [7:0] d);
        bit   ok;
        bit   acc;
        rsp_t e;
        @(negedge clk);
        req_valid[p] = 1'b1;
        req_we[p] = we;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*DW +: DW] = d;
        #1;
        wait_ready(ok);
        acc = ok && req_ready[p];
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_p%0d: got req_ready=%b required bit %0d set", p, req_ready, p);
        end
        @(posedge clk);
        if (acc) begin
            if (we) begin
                ref_mem[a] = d;
            end else begin
                e.port = p;
                e.data = ref_mem[a];
                e.chk_data = 1'b1;
                sb.push_back(e);
            end
        end
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        chk({tag, "_drain"}, 32'(sb.size()), 32'h0);
    endtask

    initial begin
        bit          ok;
        rsp_t        e;
        logic [1:0]  exp_g;
        logic [11:0] a;
        logic [7:0]  d;
        int          p;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        vecs[0] = '{0, 1'b1, 12'h123, 8'hA5, 8'h00};
        vecs[1] = '{1, 1'b0, 12'h123, 8'h00, 8'hA5};
        vecs[2] = '{1, 1'b1, 12'h000, 8'h3C, 8'h00};
        vecs[3] = '{0, 1'b0, 12'h000, 8'h00, 8'h3C};
        vecs[4] = '{0, 1'b1, 12'hFFF, 8'hFF, 8'h00};
        vecs[5] = '{1, 1'b0, 12'hFFF, 8'h00, 8'hFF};
        vecs[6] = '{1, 1'b1, 12'h123, 8'h5A, 8'h00};
        vecs[7] = '{0, 1'b0, 12'h123, 8'h00, 8'h5A};

        // Reset state, with both ports already requesting reads.
        reset = 1'b1;
        req_valid = 2'b11;
        req_we = 2'b00;
        req_addr = {12'h020, 12'h010};
        req_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Continuous contention: grants alternate (or stay on port 0 with fixed priority).
        for (int k = 0; k < 4; k++) begin
            wait_ready(ok);
`ifdef SRAM_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
            chk($sformatf("grant_%0d", k), 32'(req_ready), 32'(exp_g));
            if (ok) begin
                e.port = req_ready[1] ? 1 : 0;
                e.data = 8'h00;
                e.chk_data = 1'b0;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        drain("contention");

        // Table of single commands with cycle-accurate checks.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].we) begin
                for (int c = 1; c <= 2; c++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d_wen_n%0d", i, c), 32'(sram_write_en), 32'h1);
                    chk($sformatf("v%0d_sense_n%0d", i, c), 32'(sram_sense_en), 32'h1);
                    chk($sformatf("v%0d_addr_n%0d", i, c), 32'(sram_addr), 32'(vecs[i].addr));
                    chk($sformatf("v%0d_din_n%0d", i, c), 32'(sram_din), 32'(vecs[i].wdata));
                end
                @(negedge clk);
                chk($sformatf("v%0d_busy_n3", i), 32'(busy), 32'h0);
                chk($sformatf("v%0d_wen_n3", i), 32'(sram_write_en), 32'h0);
            end else begin
                @(negedge clk);
                chk($sformatf("v%0d_sense_n1", i), 32'(sram_sense_en), 32'h0);
                chk($sformatf("v%0d_wen_n1", i), 32'(sram_write_en), 32'h0);
                chk($sformatf("v%0d_busy_n1", i), 32'(busy), 32'h1);
                chk($sformatf("v%0d_addr_n1", i), 32'(sram_addr), 32'(vecs[i].addr));
                @(negedge clk);
                chk($sformatf("v%0d_sense_n2", i), 32'(sram_sense_en), 32'h1);
                chk($sformatf("v%0d_busy_n2", i), 32'(busy), 32'h1);
                chk($sformatf("v%0d_rspv_n2", i), 32'(rsp_valid), 32'h0);
                @(negedge clk);
                chk($sformatf("v%0d_rspv_n3", i), 32'(rsp_valid), (vecs[i].port == 1) ? 32'h2 : 32'h1);
                chk($sformatf("v%0d_rdata_n3", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
                chk($sformatf("v%0d_busy_n3", i), 32'(busy), 32'h0);
                @(negedge clk);
                chk($sformatf("v%0d_rspv_n4", i), 32'(rsp_valid), 32'h0);
                chk($sformatf("v%0d_rdata_hold", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
            end
        end
        drain("table");

        // Random write/readback pairs from alternating ports.
        for (int i = 0; i < 100; i++) begin
            p = i % 2;
            a = 12'($urandom_range(0, 4095));
            d = 8'($urandom_range(0, 255));
            issue(p, 1'b1, a, d);
            issue(1 - p, 1'b0, a, 8'h00);
        end
        drain("random");

        // Reset at N+1 of a write from port 0; port 0 must get the first grant afterwards.
        issue(0, 1'b1, 12'h055, 8'h77);
        reset = 1'b1;
        req_valid = 2'b11;
        req_we = 2'b00;
        req_addr = {12'h123, 12'h123};
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        wait_ready(ok);
        chk("post_reset_grant", 32'(req_ready), 32'h1);
        if (ok) begin
            e.port = req_ready[1] ? 1 : 0;
            e.data = ref_mem[12'h123];
            e.chk_data = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain("postreset");

        // A one-cycle request pulse while busy is ignored.
        issue(0, 1'b1, 12'h200, 8'h11);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1] = 1'b0;
        req_addr[AW +: AW] = 12'h3AA;
        #1;
        chk("pulse_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("pulse_wen", 32'(sram_write_en), 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("pulse_sense_%0d", c), 32'(sram_sense_en), 32'h1);
        end
        chk("pulse_addr", 32'(sram_addr), 32'h200);
        chk("pulse_busy", 32'(busy), 32'h0);
        drain("final");

        chk("no_overlap", 32'(overlap), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
